// File: rtl/frog_move_ctrl.sv
// frog_move_ctrl: turns button presses into animated grid hops for the frog
// sprite. Position, facing and status outputs are registered and only move on
// frame_tick. Optional river drift is enabled with `define FROG_RIVER_DRIFT_EN.
module frog_move_ctrl #(
    parameter int unsigned STEP       = 32,
    parameter int unsigned HOP_FRAMES = 4,
    parameter int unsigned X_MIN      = 0,
    parameter int unsigned X_MAX      = 608,
    parameter int unsigned Y_MIN      = 0,
    parameter int unsigned Y_MAX      = 448,
    parameter int unsigned START_X    = 304,
    parameter int unsigned START_Y    = 448
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              frame_tick,
    input  logic              respawn,
`ifdef FROG_RIVER_DRIFT_EN
    input  logic signed [3:0] drift_dx,
    output logic              edge_clamped,
`endif
    output logic [9:0]        frog_x,
    output logic [9:0]        frog_y,
    output logic [1:0]        facing,
    output logic              hopping,
    output logic              hop_done
);

    localparam int unsigned CW = $clog2(HOP_FRAMES) + 1;

    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] SUB_S  = 11'(STEP / HOP_FRAMES);
    localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
    localparam logic signed [10:0] YMIN_S = 11'(Y_MIN);
    localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic {
        IDLE,
        HOP
    } state_t;

    state_t          state;
    dir_t            hop_dir;
    dir_t            sel_dir;
    logic [CW-1:0]   frame_cnt;
    logic [3:0]      pending;

    // Buttons packed by direction code so pending[dir] lines up with facing.
    logic [3:0]      btn_raw;
    logic [3:0]      btn_s1;
    logic [3:0]      btn_s2;
    logic [3:0]      btn_d;
    logic [3:0]      btn_edge;

    logic signed [10:0] x_s;
    logic signed [10:0] y_s;
    logic signed [10:0] dx_s;
    logic signed [10:0] idle_x;
    logic signed [10:0] tgt_x;
    logic signed [10:0] tgt_y;
    logic signed [10:0] hop_x;
    logic signed [10:0] hop_y;
    logic               tgt_ok;
`ifdef FROG_RIVER_DRIFT_EN
    logic               idle_clamp;
    logic               hop_clamp;
`endif

    assign btn_raw = {btn_left, btn_down, btn_right, btn_up};
    assign x_s     = signed'({1'b0, frog_x});
    assign y_s     = signed'({1'b0, frog_y});

    // Two-flop synchronizer followed by a registered rising-edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_d    <= '0;
            btn_edge <= '0;
        end else begin
            btn_s1   <= btn_raw;
            btn_s2   <= btn_s1;
            btn_d    <= btn_s2;
            btn_edge <= btn_s2 & ~btn_d;
        end
    end

    // Direction priority, hop target / legality and per-frame step arithmetic.
    always_comb begin
        sel_dir = DIR_RIGHT;
        if (pending[DIR_UP])        sel_dir = DIR_UP;
        else if (pending[DIR_DOWN]) sel_dir = DIR_DOWN;
        else if (pending[DIR_LEFT]) sel_dir = DIR_LEFT;

`ifdef FROG_RIVER_DRIFT_EN
        dx_s = {{7{drift_dx[3]}}, drift_dx};
`else
        dx_s = '0;
`endif

        idle_x = x_s + dx_s;
`ifdef FROG_RIVER_DRIFT_EN
        idle_clamp = 1'b0;
        if (idle_x < XMIN_S) begin
            idle_x     = XMIN_S;
            idle_clamp = 1'b1;
        end else if (idle_x > XMAX_S) begin
            idle_x     = XMAX_S;
            idle_clamp = 1'b1;
        end
`endif

        tgt_x = idle_x;
        tgt_y = y_s;
        case (sel_dir)
            DIR_UP:    tgt_y = y_s - STEP_S;
            DIR_DOWN:  tgt_y = y_s + STEP_S;
            DIR_LEFT:  tgt_x = idle_x - STEP_S;
            default:   tgt_x = idle_x + STEP_S;
        endcase
        tgt_ok = (tgt_x >= XMIN_S) && (tgt_x <= XMAX_S) &&
                 (tgt_y >= YMIN_S) && (tgt_y <= YMAX_S);

        hop_x = x_s + dx_s;
        hop_y = y_s;
        case (hop_dir)
            DIR_UP:    hop_y = y_s - SUB_S;
            DIR_DOWN:  hop_y = y_s + SUB_S;
            DIR_LEFT:  hop_x = x_s + dx_s - SUB_S;
            default:   hop_x = x_s + dx_s + SUB_S;
        endcase
`ifdef FROG_RIVER_DRIFT_EN
        hop_clamp = 1'b0;
        if (hop_x < XMIN_S) begin
            hop_x     = XMIN_S;
            hop_clamp = 1'b1;
        end else if (hop_x > XMAX_S) begin
            hop_x     = XMAX_S;
            hop_clamp = 1'b1;
        end
`endif
    end

    // Motion FSM: press latching, hop start, per-frame stepping and respawn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hop_dir   <= DIR_UP;
            frame_cnt <= '0;
            pending   <= '0;
            frog_x    <= 10'(START_X);
            frog_y    <= 10'(START_Y);
            facing    <= DIR_UP;
            hopping   <= 1'b0;
            hop_done  <= 1'b0;
`ifdef FROG_RIVER_DRIFT_EN
            edge_clamped <= 1'b0;
`endif
        end else begin
            hop_done <= 1'b0;
`ifdef FROG_RIVER_DRIFT_EN
            edge_clamped <= 1'b0;
`endif
            if (respawn) begin
                state     <= IDLE;
                frame_cnt <= '0;
                pending   <= '0;
                frog_x    <= 10'(START_X);
                frog_y    <= 10'(START_Y);
                facing    <= DIR_UP;
                hopping   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (frame_tick) begin
`ifdef FROG_RIVER_DRIFT_EN
                            frog_x       <= 10'(idle_x);
                            edge_clamped <= idle_clamp;
`endif
                            if (|pending) begin
                                // Edges landing on the selecting tick are dropped
                                // along with the losing latches.
                                pending <= '0;
                                facing  <= sel_dir;
                                if (tgt_ok) begin
                                    hop_dir   <= sel_dir;
                                    frame_cnt <= '0;
                                    hopping   <= 1'b1;
                                    state     <= HOP;
                                end
                            end else begin
                                pending <= btn_edge;
                            end
                        end else begin
                            pending <= pending | btn_edge;
                        end
                    end
                    HOP: begin
                        if (frame_tick) begin
                            frog_x <= 10'(hop_x);
                            frog_y <= 10'(hop_y);
`ifdef FROG_RIVER_DRIFT_EN
                            edge_clamped <= hop_clamp;
`endif
                            if (frame_cnt == CW'(HOP_FRAMES - 1)) begin
                                frame_cnt <= '0;
                                hopping   <= 1'b0;
                                hop_done  <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                frame_cnt <= frame_cnt + CW'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/frog_move_ctrl.md
Name: frog_move_ctrl

Overview:
- Frog motion controller; sits directly upstream of the frog sprite generator and drives its frog_x, frog_y and facing inputs.
- Converts player button presses into grid hops, animated over several frames and bounded to the playfield.
- Updates position only on the per-frame tick, so the sprite stage always sees stable coordinates during active video.
- Supports respawn on death.

Parameters:
- STEP, 32, pixels per hop; equals the sprite size.
- HOP_FRAMES, 4, frames per hop animation; STEP must be divisible by HOP_FRAMES.
- X_MIN, 0, leftmost legal frog_x.
- X_MAX, 608, rightmost legal frog_x.
- Y_MIN, 0, topmost legal frog_y.
- Y_MAX, 448, bottommost legal frog_y.
- START_X, 304, respawn x.
- START_Y, 448, respawn y.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- btn_up  in  1  raw button level, asynchronous to clk.
- btn_down  in  1  raw button level, asynchronous to clk.
- btn_left  in  1  raw button level, asynchronous to clk.
- btn_right  in  1  raw button level, asynchronous to clk.
- frame_tick  in  1  one-cycle pulse once per frame (start of vertical blank).
- respawn  in  1  one-cycle pulse; return frog to start.
- frog_x  out  10  frog top-left column.
- frog_y  out  10  frog top-left row.
- facing  out  2  0=up, 1=right, 2=down, 3=left; consumed as sprite ROM bank.
- hopping  out  1  high while a hop animation is in progress.
- hop_done  out  1  one-cycle pulse when a hop completes.

Behaviour:
- Reset (async, active-high) values:
  - frog_x=START_X, frog_y=START_Y, facing=0.
  - hopping=0, hop_done=0.
  - state=IDLE, all press latches cleared, synchronizer flops cleared.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer, then a registered rising-edge detect.
  - An edge sets that direction's pending latch.
  - A held button generates exactly one press.
  - Edges arriving outside IDLE are discarded, and latches are not set.
- State IDLE, on frame_tick with any pending latch:
  - Select one direction by priority up > down > left > right.
  - Clear all pending latches.
  - facing updates to the selected direction on that same tick, whether or not the move is legal.
  - Target = current position ± STEP on the relevant axis, computed at 11 bits signed.
  - Target inside [X_MIN,X_MAX] / [Y_MIN,Y_MAX]: latch the direction, go to HOP, hopping=1 from the next cycle.
  - Target outside bounds: stay IDLE; no movement, no hop_done.
- State HOP:
  - Each frame_tick moves the frog STEP/HOP_FRAMES pixels in the latched direction and increments the frame counter (width clog2(HOP_FRAMES)+1).
  - On the HOP_FRAMES-th tick the position equals the target exactly.
  - On the cycle after that tick: hop_done=1 for one cycle, hopping=0, state=IDLE.
- Outputs are registered; position changes only in the cycle after a frame_tick (one-cycle latency).
- respawn has the highest priority, from any state, including simultaneous with frame_tick:
  - Next cycle: position=START, facing=0, state=IDLE, hopping=0, latches cleared, counter cleared.
  - No hop_done is emitted for an aborted hop.
- frame_tick with no pending press in IDLE: no change.
- Reset asserted mid-hop: immediate return to reset values.

Optional Feature:
- Macro: FROG_RIVER_DRIFT_EN.
- Defined:
  - Adds input drift_dx (4-bit signed, pixels per frame), driven by the log/river lane logic.
  - On every frame_tick, in both IDLE and HOP, frog_x += drift_dx in addition to any hop step.
  - The sum is computed at 11 bits signed and clamped to [X_MIN,X_MAX].
  - Adds output edge_clamped: a one-cycle pulse when clamping occurs.
  - In IDLE, the bounds check uses the post-drift x.
- Not defined: no drift_dx or edge_clamped ports; x changes only by hops.

Test Plan:
- Reset, then idle for 3 frame_ticks -> frog_x=304, frog_y=448, facing=0, hopping=0, no hop_done.
- Press btn_up once, then 5 frame_ticks -> facing=0; y steps 440, 432, 424, 416; hop_done pulses once after the 4th tick; hopping high for exactly that span.
- From start, press btn_down -> facing=2 after the next tick, y stays 448, hopping never asserts, no hop_done.
- Hold btn_left for 20 frames -> exactly one hop, x 304→272, facing=3; btn_right pressed mid-hop is ignored.
- btn_up and btn_left press edges land together -> up wins (y 448→416, x unchanged, facing=0).
- respawn at the 2nd tick of a hop, coincident with frame_tick -> next cycle x=304, y=448, facing=0, hopping=0, no hop_done.
- (FROG_RIVER_DRIFT_EN) drift_dx=+3 with frog_x=606 -> x=608, edge_clamped pulses.
